image_normalizer: RTL
=====================

Name: image_normalizer

Overview:
- Post-compression stage between the 32x32 compressed image buffer and the CPU-visible image memory.
- After the compressor finishes, it scans the 1024-pixel frame twice:
  - pass 1 computes the mean intensity;
  - pass 2 rewrites each pixel, inverting dark ink on a light background into bright-on-black (MNIST polarity), suppressing background, and zeroing the 2-pixel padding border.
- Started by the compress request logic; the CPU polls busy/done before running the CNN.

Parameters:
- PAD, 2, width in pixels of the border forced to 0 on every side.
- DIM, 32, image side length. Fixed at 32 (addresses are row*32+col, 10 bits).

Ports:
- clk  input  1  system clock (50 MHz domain)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- margin  input  8  background margin subtracted from the mean to form the threshold; sampled on accepted start
- src_raddr  output  10  read address into the compressed source image
- src_rdata  input  8  source pixel; valid exactly 1 cycle after src_raddr (synchronous RAM)
- dst_we  output  1  write strobe to the destination image memory
- dst_waddr  output  10  destination write address
- dst_wdata  output  8  normalized pixel
- busy  output  1  high from accepted start through the last write
- done  output  1  one-cycle pulse after the final write
- mean_out  output  8  mean of the last processed frame; held until the next CALC

Behaviour:
- Reset values: src_raddr=0, dst_we=0, dst_waddr=0, dst_wdata=0, busy=0, done=0, mean_out=0. State=IDLE, accumulator=0.
- Reset asserted mid-operation aborts immediately:
  - no further dst_we;
  - the destination keeps whatever was already written.
- FSM states: IDLE, SUM, SUM_DRAIN, CALC, NORM, NORM_DRAIN, DONE.
- IDLE:
  - start=1 latches margin, clears the 18-bit accumulator and src_raddr, sets busy, goes to SUM.
  - start=0 stays in IDLE.
- SUM:
  - src_raddr increments 0..1023, one per cycle.
  - A 1-cycle-delayed valid flag adds src_rdata into the accumulator.
  - After issuing address 1023, goes to SUM_DRAIN. The address counter wraps to 0.
- SUM_DRAIN: accumulates the final pixel (1 cycle), goes to CALC.
- CALC (1 cycle):
  - mean = acc[17:10] (sum/1024, truncating).
  - thr = mean - margin, saturating at 0 (9-bit compare, no wrap).
  - mean_out updated. src_raddr=0. Goes to NORM.
- NORM:
  - src_raddr increments 0..1023.
  - Each returning pixel p at address a is written 1 cycle later: dst_we=1, dst_waddr=a, dst_wdata=f(p,a).
  - f = 0 if row<PAD, row>=DIM-PAD, col<PAD or col>=DIM-PAD (row=a[9:5], col=a[4:0]).
  - Otherwise f = 255-p when p<thr, else 0.
- NORM_DRAIN: writes pixel 1023, goes to DONE.
- DONE: done=1 and busy=0 for 1 cycle, then IDLE.
- Timing:
  - Exactly 1024 writes per run, one per cycle, ascending address, no gaps.
  - Start-to-done latency is 2054 cycles:
    - SUM 1024, SUM_DRAIN 1, CALC 1, NORM 1024, NORM_DRAIN 1, DONE 1;
    - plus 2 cycles from start capture and the first NORM pipeline stage.
  - The bench checks the exact count after the first implementation and freezes it.
- start while busy is ignored (not queued).
- start in the DONE cycle is ignored.
- start arriving the cycle after DONE (back in IDLE) is accepted.
- thr=0 (margin>=mean) means every output pixel is 0.
- All-255 input gives mean=255.
- Accumulator maximum is 1024*255 = 261120, which fits in 18 bits with no overflow.

Optional Feature:
- Macro: IMG_NORM_BINARIZE_EN.
- Defined: the non-border output is 255 when p<thr, else 0 (hard binary image). mean_out and timing are unchanged.
- Undefined: graded output 255-p as specified above.

Test Plan:
- Reset mid-NORM (assert rst_n=0 at write 500) -> busy=0 and dst_we=0 immediately; no writes after release; the next start runs a full 1024-write pass.
- Uniform source 200, margin=10 -> mean_out=200, thr=190; all 1024 outputs 0; done exactly once; busy high for the whole run.
- Background 220 with a 10x10 interior block of 40 at rows/cols 10..19, margin=20:
  - mean = (924*220 + 100*40)/1024 = 202, thr=182;
  - block pixels -> 215 (binarize build: 255); all others 0.
- Border check, source pixel 0 everywhere except address 0 = 0 and address 33 = 0 (source all zero, margin=0) -> mean=0, thr=0, all outputs 0. Repeat with source all 10, margin=0, addresses 66 and 0 set to 0 -> address 66 (row 2, col 2) outputs 255; address 0 (border) outputs 0.
- start pulsed at cycles 5, 100 and 1500 after the first accepted start -> only one run; exactly 1024 dst_we pulses; done once.
- Source gradient p=a[7:0], margin=0 -> mean_out=127; interior pixel with p=100 outputs 155; interior pixel with p=127 outputs 0.

Source files
------------

// File: rtl/image_normalizer.sv
// ---------------------------------------------------------------------------
// image_normalizer
//
// Post-compression stage that sits between the 32x32 compressed image buffer
// and the CPU-visible image memory. After each start it scans the 1024-pixel
// source frame twice:
//   pass 1 (SUM)  : accumulates every pixel to find the mean intensity;
//   pass 2 (NORM) : rewrites every pixel into the destination memory,
//                   turning dark ink on a light background into bright-on-black,
//                   suppressing background and forcing a PAD-wide border to 0.
//
// Optional build macro:
//   IMG_NORM_BINARIZE_EN - when defined, interior ink pixels are written as 255
//                          (hard binary image) instead of the graded 255-p.
//                          Mean and timing are identical in both builds.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset; aborts a run immediately
//   start        in   single-cycle request, only honoured in IDLE
//   margin[7:0]  in   margin subtracted from the mean to form the threshold,
//                     captured together with an accepted start
//   src_raddr    out  source read address (row*32+col)
//   src_rdata    in   source pixel, valid one cycle after src_raddr
//   dst_we       out  destination write strobe
//   dst_waddr    out  destination write address
//   dst_wdata    out  normalized pixel
//   busy         out  high from the accepted start through the last write
//   done         out  one-cycle pulse after the final write
//   mean_out     out  mean of the last processed frame
//   dbg_state_o  out  current FSM state encoding (debug visibility)
//
// Handshake: there is no backpressure. A start seen in IDLE is accepted; any
// start seen in another state is dropped, not queued. The source RAM must
// return data exactly one cycle after the address; the destination must accept
// one write per cycle while dst_we is high.
// ---------------------------------------------------------------------------
module image_normalizer #(
    parameter int PAD = 2,
    parameter int DIM = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] margin,
    output logic [9:0] src_raddr,
    input  logic [7:0] src_rdata,
    output logic       dst_we,
    output logic [9:0] dst_waddr,
    output logic [7:0] dst_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] mean_out,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SUM        = 3'd1,
        S_SUM_DRAIN  = 3'd2,
        S_CALC       = 3'd3,
        S_NORM       = 3'd4,
        S_NORM_DRAIN = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    localparam logic [9:0] LAST_ADDR = 10'd1023;
    localparam logic [4:0] BORDER_LO = 5'(PAD);
    localparam logic [4:0] BORDER_HI = 5'(DIM - PAD);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [9:0]  raddr_q,  raddr_d;
    logic [7:0]  margin_q, margin_d;
    logic [17:0] acc_q,    acc_d;
    logic [7:0]  mean_q,   mean_d;
    logic [7:0]  thr_q,    thr_d;

    // Read pipeline: flags mark that src_rdata this cycle belongs to the
    // address issued in the previous cycle, for the sum or the norm pass.
    logic        sum_vld_q;
    logic        norm_vld_q;
    logic [9:0]  paddr_q;

    // Registered write port and status
    logic        we_q;
    logic [9:0]  waddr_q;
    logic [7:0]  wdata_q,  wdata_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    // Threshold arithmetic is done one bit wider so a margin above the mean
    // shows up as a borrow instead of wrapping around.
    logic [8:0]  thr_diff;
    logic        in_border;
    logic [4:0]  pix_row;
    logic [4:0]  pix_col;

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        margin_d = margin_q;
        acc_d    = acc_q;
        mean_d   = mean_q;
        thr_d    = thr_q;
        thr_diff = {1'b0, acc_q[17:10]} - {1'b0, margin_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    margin_d = margin;
                    acc_d    = '0;
                    raddr_d  = '0;
                    state_d  = S_SUM;
                end
            end
            S_SUM: begin
                raddr_d = raddr_q + 10'd1;
                if (raddr_q == LAST_ADDR) begin
                    state_d = S_SUM_DRAIN;
                end
            end
            S_SUM_DRAIN: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                // Mean is sum/1024, truncating; threshold saturates at 0.
                mean_d  = acc_q[17:10];
                thr_d   = thr_diff[8] ? 8'd0 : thr_diff[7:0];
                raddr_d = '0;
                state_d = S_NORM;
            end
            S_NORM: begin
                raddr_d = raddr_q + 10'd1;
                if (raddr_q == LAST_ADDR) begin
                    state_d = S_NORM_DRAIN;
                end
            end
            S_NORM_DRAIN: begin
                // Stay until pixel 1023 has left the read pipeline and been
                // registered onto the write port, so done follows the last write.
                if (!norm_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accumulate the pixel that returns one cycle after its SUM address.
        // 1024*255 = 261120 fits in 18 bits, so no overflow handling is needed.
        if (sum_vld_q) begin
            acc_d = acc_q + {10'd0, src_rdata};
        end
    end

    // -----------------------------------------------------------------------
    // Pixel transform for the norm pass
    // -----------------------------------------------------------------------
    always_comb begin
        pix_row   = paddr_q[9:5];
        pix_col   = paddr_q[4:0];
        in_border = (pix_row < BORDER_LO) || (pix_row >= BORDER_HI) ||
                    (pix_col < BORDER_LO) || (pix_col >= BORDER_HI);
        wdata_d   = 8'd0;
        if (!in_border && (src_rdata < thr_q)) begin
`ifdef IMG_NORM_BINARIZE_EN
            wdata_d = 8'd255;
`else
            wdata_d = 8'd255 - src_rdata;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs are registered from the next state so they line up with
    // the state the FSM is in during that cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d == S_SUM)  || (state_d == S_SUM_DRAIN) ||
                 (state_d == S_CALC) || (state_d == S_NORM)      ||
                 (state_d == S_NORM_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            margin_q   <= '0;
            acc_q      <= '0;
            mean_q     <= '0;
            thr_q      <= '0;
            sum_vld_q  <= 1'b0;
            norm_vld_q <= 1'b0;
            paddr_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            margin_q   <= margin_d;
            acc_q      <= acc_d;
            mean_q     <= mean_d;
            thr_q      <= thr_d;
            sum_vld_q  <= (state_q == S_SUM);
            norm_vld_q <= (state_q == S_NORM);
            paddr_q    <= raddr_q;
            we_q       <= norm_vld_q;
            if (norm_vld_q) begin
                waddr_q <= paddr_q;
                wdata_q <= wdata_d;
            end
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign src_raddr   = raddr_q;
    assign dst_we      = we_q;
    assign dst_waddr   = waddr_q;
    assign dst_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mean_out    = mean_q;
    assign dbg_state_o = state_q;

endmodule
